// File: rtl/bram_frame_reader.sv
// bram_frame_reader: raster-scans one frame out of a 24-bit RGB BRAM and emits a
// valid/ready pixel stream carrying raw RGB, luma and sof/eol/eof markers.
module bram_frame_reader #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 24,
  parameter int IMG_W  = 50,
  parameter int IMG_H  = 50,
  parameter int RD_LAT = 1
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  input  logic [DATA_W-1:0] bram_douta,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [7:0]        m_gray,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof
);

  localparam int DEPTH = RD_LAT + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int COL_W = $clog2(IMG_W + 1);
  localparam int ROW_W = $clog2(IMG_H + 1);
  localparam int ENT_W = DATA_W + 3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  ena_q, ena_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [RD_LAT-1:0]     vld_q, vld_d;
  logic [3*RD_LAT-1:0]   flg_q, flg_d;
  logic [ENT_W-1:0]      fifo_q [DEPTH];
  logic [ENT_W-1:0]      fifo_d [DEPTH];
  logic [PTR_W-1:0]      wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [2:0]            iss_flg_s;
  logic                  wr_s, rd_s, credit_s;
  logic [7:0]            occ_s;
  logic [ENT_W-1:0]      head_s;

  function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
    logic [15:0] sum;
    sum = 16'd77 * {8'd0, r} + 16'd150 * {8'd0, g} + 16'd29 * {8'd0, b};
    return sum[15:8];
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Read pipeline tracking and show-ahead FIFO bookkeeping.
  always_comb begin
    iss_flg_s[0] = (col_q == {COL_W{1'b0}}) && (row_q == {ROW_W{1'b0}});
    iss_flg_s[1] = (col_q == COL_W'(IMG_W - 1));
    iss_flg_s[2] = iss_flg_s[1] && (row_q == ROW_W'(IMG_H - 1));
    vld_d = RD_LAT'({vld_q, ena_q});
    flg_d = (3 * RD_LAT)'({flg_q, iss_flg_s});

    wr_s   = vld_q[RD_LAT-1];
    rd_s   = (cnt_q != {CNT_W{1'b0}}) && m_ready;
    head_s = fifo_q[rp_q];
    fifo_d = fifo_q;
    if (wr_s) begin
      fifo_d[wp_q] = {flg_q[3*RD_LAT-1 -: 3], bram_douta};
    end else begin
      fifo_d[wp_q] = fifo_q[wp_q];
    end
    wp_d = wr_s ? ptr_inc(wp_q) : wp_q;
    rp_d = rd_s ? ptr_inc(rp_q) : rp_q;
    case ({wr_s, rd_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // Count what will occupy the FIFO if downstream stalls forever from now on.
    occ_s    = 8'(cnt_q) + 8'($countones(vld_q)) + 8'(ena_q) - 8'(rd_s);
    credit_s = (occ_s < 8'(DEPTH));
  end

  // Frame FSM and address/column/row generation.
  always_comb begin
    state_d = state_q;
    ena_d   = 1'b0;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    if (ena_q) begin
      addr_d = addr_q + ADDR_W'(1);
      if (iss_flg_s[1]) begin
        col_d = {COL_W{1'b0}};
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else begin
      addr_d = addr_q;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          ena_d   = 1'b1;
          addr_d  = {ADDR_W{1'b0}};
          col_d   = {COL_W{1'b0}};
          row_d   = {ROW_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (ena_q && (addr_q == LAST_ADDR)) begin
          state_d = S_DRAIN;
        end else begin
          ena_d = credit_s;
        end
      end
      S_DRAIN: begin
        if (rd_s && head_s[ENT_W-1]) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and pipeline state; reset also discards reads still in flight.
  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q <= S_IDLE;
      ena_q   <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      col_q   <= {COL_W{1'b0}};
      row_q   <= {ROW_W{1'b0}};
      vld_q   <= {RD_LAT{1'b0}};
      flg_q   <= {(3 * RD_LAT){1'b0}};
      wp_q    <= {PTR_W{1'b0}};
      rp_q    <= {PTR_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      ena_q   <= ena_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      vld_q   <= vld_d;
      flg_q   <= flg_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO payload storage; emptiness is tracked by cnt_q, so no reset needed.
  always_ff @(posedge clka) begin
    fifo_q <= fifo_d;
  end

  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign bram_ena   = ena_q;
  assign bram_wea   = 1'b0;
  assign bram_addra = addr_q;
  assign m_valid    = (cnt_q != {CNT_W{1'b0}});
  assign m_data     = head_s[DATA_W-1:0];
  assign m_sof      = m_valid & head_s[DATA_W];
  assign m_eol      = m_valid & head_s[DATA_W+1];
  assign m_eof      = m_valid & head_s[DATA_W+2];
  assign m_gray     = luma(m_data[DATA_W-1 -: 8], m_data[DATA_W-9 -: 8], m_data[7:0]);

endmodule

// File: tb/tb_bram_frame_reader.sv
// Self-checking bench: two readers (read latency 1 and 2) share stimulus and are
// each scored against a frame-level model of beats, markers, timing and credits.
module tb_bram_frame_reader;
  localparam int W  = 50;
  localparam int H  = 50;
  localparam int N  = W * H;
  localparam int AW = 18;
  localparam int DW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rsta, start, m_ready;
  logic          busy [2], done [2], ena [2], wea [2], valid [2];
  logic          sof [2], eol [2], eof [2];
  logic [AW-1:0] addra [2];
  logic [DW-1:0] douta [2], mdata [2];
  logic [7:0]    gray [2];
  logic [DW-1:0] mem [0:4095];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int active [2], k [2], issued [2], xfer [2], exp_done [2], frames [2];
  int acc_cyc [2], seen_valid [2], stall_pend [2], rate_off [2];
  logic [31:0] stall_word [2];
  logic rst_prev = 1'b0;
  int rate_arm = 0;
  int rand_ready = 0;
  int pat_mode = 0;
  logic [DW-1:0] ptab [4] = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h00FF00};
  // (77*255)>>8 = 76 and (150*255)>>8 = 149
  int gtab [4] = '{255, 0, 76, 149};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] s1_q, s2_q;
    bram_frame_reader #(.ADDR_W(AW), .DATA_W(DW), .IMG_W(W), .IMG_H(H), .RD_LAT(g + 1)) u_dut (
      .clka(clk), .rsta(rsta), .start(start), .busy(busy[g]), .done(done[g]),
      .bram_ena(ena[g]), .bram_wea(wea[g]), .bram_addra(addra[g]), .bram_douta(douta[g]),
      .m_valid(valid[g]), .m_ready(m_ready), .m_data(mdata[g]), .m_gray(gray[g]),
      .m_sof(sof[g]), .m_eol(eol[g]), .m_eof(eof[g]));
    always @(posedge clk) begin
      if (ena[g]) s1_q <= mem[addra[g]];
      s2_q <= s1_q;
    end
    assign douta[g] = (g == 0) ? s1_q : s2_q;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic string tg(input string s, input int i);
    return $sformatf("%s/lat%0d", s, i + 1);
  endfunction

  function automatic int gray_ref(input logic [DW-1:0] p);
    return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
  endfunction

  // Scoreboard: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rsta) begin
        active[i] = 0; k[i] = 0; issued[i] = 0; xfer[i] = 0;
        exp_done[i] = -1; seen_valid[i] = 0; stall_pend[i] = 0;
      end else begin
        if (rst_prev) begin
          chk_eq(tg("rst_outs", i), {busy[i], done[i], ena[i], valid[i], sof[i], eol[i], eof[i]}, 0);
          chk_eq(tg("rst_addr", i), addra[i], 0);
        end
        chk_eq(tg("wea", i), wea[i], 0);
        if (active[i] == 0) begin
          chk_eq(tg("idle_outs", i), {valid[i], ena[i], busy[i], done[i]}, 0);
          if (start) begin
            active[i] = 1; acc_cyc[i] = cyc; k[i] = 0; issued[i] = 0; xfer[i] = 0;
            seen_valid[i] = 0; stall_pend[i] = 0; rate_off[i] = -1; exp_done[i] = -1;
          end
        end else begin
          if (ena[i]) begin
            chk_eq(tg("addr", i), addra[i], issued[i]);
            issued[i]++;
          end
          if (valid[i] && seen_valid[i] == 0) begin
            chk_eq(tg("first_lat", i), cyc - acc_cyc[i], i + 3);
            seen_valid[i] = 1;
          end
          if (stall_pend[i] != 0)
            chk_eq(tg("stall_hold", i), {valid[i], sof[i], eol[i], eof[i], mdata[i]}, stall_word[i]);
          stall_pend[i] = (valid[i] && !m_ready) ? 1 : 0;
          stall_word[i] = {valid[i], sof[i], eol[i], eof[i], mdata[i]};
          if (valid[i] && m_ready) begin
            if (k[i] >= N) begin
              chk_eq(tg("extra_beat", i), k[i], N - 1);
            end else begin
              chk_eq(tg("data", i), mdata[i], mem[k[i]]);
              chk_eq(tg("sof", i), sof[i], k[i] == 0);
              chk_eq(tg("eol", i), eol[i], (k[i] % W) == W - 1);
              chk_eq(tg("eof", i), eof[i], k[i] == N - 1);
              chk_eq(tg("gray", i), gray[i], gray_ref(mem[k[i]]));
              if (pat_mode == 1) chk_eq(tg("gray_tab", i), gray[i], gtab[k[i] % 4]);
              if (k[i] == N - 1) exp_done[i] = cyc + 1;
              if (rate_arm != 0) begin
                if (rate_off[i] < 0) rate_off[i] = cyc - k[i];
                else chk_eq(tg("rate", i), cyc - k[i], rate_off[i]);
              end
            end
            xfer[i]++; k[i]++;
          end
          if (ena[i]) chk_eq(tg("credit", i), (issued[i] - xfer[i]) <= i + 3, 1);
          chk_eq(tg("done", i), done[i], cyc == exp_done[i]);
          chk_eq(tg("busy", i), busy[i], cyc != exp_done[i]);
          if (cyc == exp_done[i]) begin
            active[i] = 0; frames[i]++;
          end
        end
      end
    end
    rst_prev = rsta;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_frames(input int tgt);
    int n = 0;
    while ((frames[0] < tgt || frames[1] < tgt) && n < 20000) begin
      @(posedge clk); #1;
      n++;
      if (rand_ready != 0) m_ready = 1'($urandom_range(0, 1));
    end
    chk_eq($sformatf("frames_reach_%0d", tgt), (frames[0] >= tgt) && (frames[1] >= tgt), 1);
  endtask

  task automatic wait_xfer(input int tgt);
    int n = 0;
    while (xfer[0] < tgt && xfer[1] < tgt && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk_eq($sformatf("xfer_reach_%0d", tgt), (xfer[0] >= tgt) || (xfer[1] >= tgt), 1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      frames[i] = 0; active[i] = 0; exp_done[i] = -1; rate_off[i] = -1;
    end
    for (int a = 0; a < 4096; a++) mem[a] = DW'(a);
    rsta = 1'b1; start = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rsta = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Frame 1: identity image, full rate.
    rate_arm = 1;
    pulse_start();
    wait_frames(1);

    // Frame 2: random pixels, random back-pressure.
    for (int a = 0; a < N; a++) mem[a] = DW'($urandom);
    rate_arm = 0; rand_ready = 1;
    pulse_start();
    wait_frames(2);
    rand_ready = 0; m_ready = 1'b1;

    // Frame 3: luma corner values.
    for (int a = 0; a < N; a++) mem[a] = ptab[a % 4];
    pat_mode = 1; rate_arm = 1;
    pulse_start();
    wait_frames(3);
    pat_mode = 0;

    // Frames 4-5: start ignored in RUN; start held across DONE launches one frame.
    for (int a = 0; a < N; a++) mem[a] = DW'(a);
    pulse_start();
    repeat (100) @(posedge clk);
    #1;
    pulse_start();
    wait_xfer(N - 20);
    start = 1'b1;
    for (int n = 0; n < 20000 && !(frames[0] >= 4 && frames[1] >= 4 && active[0] != 0 && active[1] != 0); n++) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_frames(5);
    repeat (50) @(posedge clk);
    #1;
    chk_eq("frame_count0", frames[0], 5);
    chk_eq("frame_count1", frames[1], 5);

    // Frame 6: abort at beat 1000, then a clean frame.
    pulse_start();
    wait_xfer(1000);
    rsta = 1'b1;
    @(posedge clk); #1 rsta = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk_eq("abort_no_done0", frames[0], 5);
    pulse_start();
    wait_frames(6);

    // Frame 7: 20-cycle stall from the first valid, then full-rate release.
    m_ready = 1'b0; rate_arm = 0;
    pulse_start();
    repeat (22) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk_eq(tg("stall_issued", i), issued[i], i + 3);
      chk_eq(tg("stall_ena", i), ena[i], 0);
      chk_eq(tg("stall_valid", i), valid[i], 1);
      rate_off[i] = -1;
    end
    rate_arm = 1; m_ready = 1'b1;
    wait_frames(7);
    repeat (10) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
